// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: raster timing and 18-bit RGB (external source or test patterns) for an LVDS transmitter; ports clk, rst, mode, pix_req/pix_x/pix_y/pix_data, frame_start, HSync, VSync, DataEnable, Red, Green, Blue
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int BAR_W    = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  input  logic [17:0] pix_data,
  output logic        frame_start,
  output logic        HSync,
  output logic        VSync,
  output logic        DataEnable,
  output logic [5:0]  Red,
  output logic [5:0]  Green,
  output logic [5:0]  Blue
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] B_LAST = 11'(BAR_W - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  logic [10:0] h, bar_cnt;
  logic [9:0]  v;
  logic        fc, fc1;
  logic [2:0]  bar_idx, bar1;
  logic [1:0]  mode_r, mode_eff, m1, m2;
  logic        h_wrap, v_wrap, at_origin, active, in_hs, in_vs;
  logic        hs1, vs1, de2, hs2, vs2;
  logic [17:0] int_rgb, c2, d2;
  assign h_wrap    = h == H_LAST;
  assign v_wrap    = v == V_LAST;
  assign at_origin = h == 11'd0 && v == 10'd0;
  assign active    = h < H_ACT && v < V_ACT;
  assign in_hs     = h >= HS_BEG && h < HS_END;
  assign in_vs     = v >= VS_BEG && v < VS_END;
  // the frame starting at the origin already uses the mode sampled there
  assign mode_eff  = at_origin ? mode : mode_r;
  // bar colour bits: red for indices 0,1,4,5; green for 0-3; blue for even indices
  assign int_rgb = m1 == 2'd1 ? {{6{~bar1[1]}}, {6{~bar1[2]}}, {6{~bar1[0]}}} :
                   m1 == 2'd2 ? {3{pix_x[5:0]}} :
                   {18{pix_x[3] ^ pix_y[3] ^ fc1}};
  always_ff @(posedge clk) begin
    if (rst) begin
      h           <= '0;
      v           <= '0;
      fc          <= 1'b0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      mode_r      <= mode;
      pix_req     <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      hs1         <= ~HS_POL;
      vs1         <= ~VS_POL;
      fc1         <= 1'b0;
      bar1        <= '0;
      m1          <= '0;
      de2         <= 1'b0;
      hs2         <= ~HS_POL;
      vs2         <= ~VS_POL;
      m2          <= '0;
      c2          <= '0;
      d2          <= '0;
      DataEnable  <= 1'b0;
      HSync       <= ~HS_POL;
      VSync       <= ~VS_POL;
      Red         <= '0;
      Green       <= '0;
      Blue        <= '0;
    end else begin
      h <= h_wrap ? 11'd0 : h + 11'd1;
      if (h_wrap) v <= v_wrap ? 10'd0 : v + 10'd1;
      if (h_wrap && v_wrap) fc <= ~fc;
      // bar index tracks h / BAR_W without a divider, saturating at 7
      bar_cnt <= (h_wrap || bar_cnt == B_LAST) ? 11'd0 : bar_cnt + 11'd1;
      bar_idx <= h_wrap ? 3'd0 : (bar_cnt == B_LAST && bar_idx != 3'd7) ? bar_idx + 3'd1 : bar_idx;
      if (at_origin) mode_r <= mode;
      pix_req     <= active;
      if (active) pix_x <= h;
      if (active) pix_y <= v;
      frame_start <= at_origin;
      hs1         <= in_hs ? HS_POL : ~HS_POL;
      vs1         <= in_vs ? VS_POL : ~VS_POL;
      fc1         <= fc;
      bar1        <= bar_idx;
      m1          <= mode_eff;
      de2         <= pix_req;
      hs2         <= hs1;
      vs2         <= vs1;
      m2          <= m1;
      c2          <= int_rgb;
      d2          <= pix_data;
      DataEnable  <= de2;
      HSync       <= hs2;
      VSync       <= vs2;
      {Red, Green, Blue} <= de2 ? (m2 == 2'd0 ? d2 : c2) : 18'd0;
    end
  end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: checks lcd_timing_gen against a position-based raster model plus pinned literal points
module tb_lcd_timing_gen;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  mode = 2'd1;
  logic [17:0] pix_data = '0;
  logic        pix_req, frame_start, HSync, VSync, DataEnable;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [5:0]  Red, Green, Blue;
  int total = 0, bad = 0, k = 0;
  bit mon_en = 1'b0;
  logic [1:0]  fmode [16];
  logic [17:0] bars [8] = '{18'h3ffff, {6'd63, 6'd63, 6'd0}, {6'd0, 6'd63, 6'd63}, {6'd0, 6'd63, 6'd0},
                           {6'd63, 6'd0, 6'd63}, {6'd63, 6'd0, 6'd0}, {6'd0, 6'd0, 6'd63}, 18'd0};

  lcd_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2),
                   .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0), .BAR_W(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .frame_start(frame_start), .HSync(HSync), .VSync(VSync),
    .DataEnable(DataEnable), .Red(Red), .Green(Green), .Blue(Blue));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", n, a, e, k);
    end
  endtask

  function automatic int hp(int p); return p % 24; endfunction
  function automatic int vp(int p); return (p / 24) % 8; endfunction
  function automatic bit act(int p); return hp(p) < 16 && vp(p) < 4; endfunction

  function automatic logic [17:0] exp_rgb(int p);
    int h = hp(p), v = vp(p), f = p / 192, b;
    logic [1:0] m = fmode[f % 16];
    if (!act(p)) return 18'd0;
    case (m)
      2'd0: return {4'(v), 3'b000, 11'(h)};
      2'd1: begin b = h / 2 > 7 ? 7 : h / 2; return bars[b]; end
      2'd2: return {3{6'(h % 64)}};
      default: return ((h / 8 + v / 8 + f) % 2) != 0 ? 18'h3ffff : 18'd0;
    endcase
  endfunction

  // external source: returns data for the requested pixel one clock later
  initial forever begin
    @(posedge clk);
    #1;
    pix_data = pix_req ? {pix_y[3:0], 3'b000, pix_x} : 18'd0;
  end

  // k = clocks since reset release; records the mode each frame starts with
  always @(posedge clk)
    if (rst) k <= 0;
    else begin
      if (k % 192 == 0) fmode[(k / 192) % 16] <= mode;
      k <= k + 1;
    end

  always @(negedge clk)
    if (mon_en) begin
      if (k < 1) begin
        chk("pix_req", pix_req, 0);
        chk("frame_start", frame_start, 0);
        chk("pix_x", pix_x, 0);
      end else begin
        chk("pix_req", pix_req, act(k - 1));
        chk("frame_start", frame_start, (k - 1) % 192 == 0);
        if (act(k - 1)) begin
          chk("pix_x", pix_x, hp(k - 1));
          chk("pix_y", pix_y, vp(k - 1));
        end
      end
      if (k < 3) begin
        chk("de", DataEnable, 0);
        chk("hsync", HSync, 1);
        chk("vsync", VSync, 1);
        chk("rgb", {Red, Green, Blue}, 0);
      end else begin
        chk("de", DataEnable, act(k - 3));
        chk("hsync", HSync, !(hp(k - 3) >= 18 && hp(k - 3) < 21));
        chk("vsync", VSync, !(vp(k - 3) >= 5 && vp(k - 3) < 7));
        chk("rgb", {Red, Green, Blue}, exp_rgb(k - 3));
      end
    end

  task automatic wait_k(input int t);
    while (k < t) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("rst_de", DataEnable, 0);
    chk("rst_hsync", HSync, 1);
    chk("rst_vsync", VSync, 1);
    chk("rst_req", pix_req, 0);
    rst = 1'b0;
    wait_k(1);
    chk("fs_first", frame_start, 1);
    chk("req_first", pix_req, 1);
    wait_k(2);
    chk("fs_once", frame_start, 0);
    chk("de_not_yet", DataEnable, 0);
    wait_k(3);
    chk("de_rise", DataEnable, 1);
    chk("bar_white", {Red, Green, Blue}, 18'h3ffff);
    wait_k(5);
    chk("bar_yellow", {Red, Green, Blue}, {6'd63, 6'd63, 6'd0});
    wait_k(17);
    chk("bar_black_de", DataEnable, 1);
    chk("bar_black", {Red, Green, Blue}, 18'd0);
    wait_k(19);
    chk("de_fall", DataEnable, 0);
    wait_k(20);
    chk("hs_before", HSync, 1);
    wait_k(21);
    chk("hs_start", HSync, 0);
    wait_k(50);
    mode = 2'd2;
    wait_k(122);
    chk("vs_before", VSync, 1);
    wait_k(123);
    chk("vs_start", VSync, 0);
    wait_k(193);
    chk("fs_period", frame_start, 1);
    wait_k(200);
    chk("grad5", {Red, Green, Blue}, {6'd5, 6'd5, 6'd5});
    wait_k(400);
    rst = 1'b1;
    mode = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    wait_k(4);
    chk("ext_x1", {Red, Green, Blue}, 18'd1);
    wait_k(27);
    chk("ext_y1_red", Red, 4);
    wait_k(200);
    rst = 1'b1;
    mode = 2'd3;
    @(negedge clk);
    rst = 1'b0;
    wait_k(3);
    chk("chk_f0_00", Red, 0);
    wait_k(11);
    chk("chk_f0_80", Red, 63);
    wait_k(195);
    chk("chk_f1_00", Red, 63);
    wait_k(200);
    chk("mid_de_before", DataEnable, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_de", DataEnable, 0);
    chk("mid_hsync", HSync, 1);
    chk("mid_vsync", VSync, 1);
    chk("mid_rgb", {Red, Green, Blue}, 0);
    rst = 1'b0;
    mode = 2'd1;
    wait_k(1);
    chk("mid_fs", frame_start, 1);
    wait_k(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
